// File: rtl/conv_scan_ctrl.sv
// Frame scanner for the 3x3 conv engine: streams each 3x3 window from the pixel RAM into conv,
// waits out the engine latency and writes the captured result to the result RAM in raster order.
module conv_scan_ctrl #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int CONV_LAT = 1,
  parameter int AW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pix_re,
  output logic [AW-1:0] pix_addr,
  input  logic [7:0]    pix_rdata,
  output logic          conv_data_in,
  output logic [1:0]    conv_row,
  output logic [1:0]    conv_col,
  output logic [7:0]    conv_data,
  input  logic [7:0]    conv_out,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [7:0]    res_data
);

  localparam int LW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam logic [AW-1:0] IMG_W_A   = AW'(IMG_W);
  localparam logic [AW-1:0] OUT_W_A   = AW'(IMG_W - 2);
  localparam logic [AW-1:0] LAST_WR   = AW'(IMG_H - 3);
  localparam logic [AW-1:0] LAST_WC   = AW'(IMG_W - 3);
  localparam logic [LW-1:0] WAIT_LAST = LW'(CONV_LAT - 1);

  if (IMG_W < 3 || IMG_H < 3) begin : g_dim_chk
    $error("conv_scan_ctrl: image must be at least 3x3");
  end
  if (CONV_LAT < 1) begin : g_lat_chk
    $error("conv_scan_ctrl: CONV_LAT must be at least 1");
  end
  if (64'(IMG_W) * 64'(IMG_H) > (64'd1 << AW)) begin : g_aw_chk
    $error("conv_scan_ctrl: image does not fit in AW address bits");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] wr_reg;
  logic [AW-1:0] wc_reg;
  logic [1:0]    kr_reg;
  logic [1:0]    kc_reg;
  logic [LW-1:0] wait_reg;

  logic          busy_reg;
  logic          done_reg;
  logic          pix_re_reg;
  logic [AW-1:0] pix_addr_reg;
  logic          ld_reg;
  logic [1:0]    ld_row_reg;
  logic [1:0]    ld_col_reg;
  logic          res_we_reg;
  logic [AW-1:0] res_addr_reg;

  logic [1:0]    kr_next;
  logic [1:0]    kc_next;
  logic          k_last;
  logic          win_last;
  logic [AW-1:0] wr_next;
  logic [AW-1:0] wc_next;
  logic [AW-1:0] issue_addr_next;
  logic [AW-1:0] first_addr_next;
  logic [AW-1:0] store_addr_next;

  always_comb begin
    k_last   = (kr_reg == 2'd2) && (kc_reg == 2'd2);
    win_last = (wr_reg == LAST_WR) && (wc_reg == LAST_WC);
    kr_next  = kr_reg;
    kc_next  = kc_reg + 2'd1;
    if (kc_reg == 2'd2) begin
      kr_next = kr_reg + 2'd1;
      kc_next = 2'd0;
    end
    wr_next = wr_reg;
    wc_next = wc_reg + 1'b1;
    if (wc_reg == LAST_WC) begin
      wr_next = wr_reg + 1'b1;
      wc_next = '0;
    end
    issue_addr_next = (wr_reg + AW'(kr_next)) * IMG_W_A + wc_reg + AW'(kc_next);
    first_addr_next = wr_next * IMG_W_A + wc_next;
    store_addr_next = wr_reg * OUT_W_A + wc_reg;
  end

  // Outputs are set on the edge entering the state they belong to, so they are valid for
  // exactly that state's cycle; the conv load stage trails the RAM read by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wr_reg       <= '0;
      wc_reg       <= '0;
      kr_reg       <= 2'd0;
      kc_reg       <= 2'd0;
      wait_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      pix_re_reg   <= 1'b0;
      pix_addr_reg <= '0;
      ld_reg       <= 1'b0;
      ld_row_reg   <= 2'd0;
      ld_col_reg   <= 2'd0;
      res_we_reg   <= 1'b0;
      res_addr_reg <= '0;
    end else begin
      pix_re_reg   <= 1'b0;
      pix_addr_reg <= '0;
      res_we_reg   <= 1'b0;
      res_addr_reg <= '0;
      done_reg     <= 1'b0;
      ld_reg       <= pix_re_reg;
      ld_row_reg   <= pix_re_reg ? kr_reg : 2'd0;
      ld_col_reg   <= pix_re_reg ? kc_reg : 2'd0;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            wr_reg       <= '0;
            wc_reg       <= '0;
            kr_reg       <= 2'd0;
            kc_reg       <= 2'd0;
            pix_re_reg   <= 1'b1;
            pix_addr_reg <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (k_last) begin
            wait_reg  <= '0;
            state_reg <= S_WAIT;
          end else begin
            kr_reg       <= kr_next;
            kc_reg       <= kc_next;
            pix_re_reg   <= 1'b1;
            pix_addr_reg <= issue_addr_next;
          end
        end
        S_WAIT: begin
          if (wait_reg == WAIT_LAST) begin
            res_we_reg   <= 1'b1;
            res_addr_reg <= store_addr_next;
            state_reg    <= S_STORE;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        S_STORE: begin
          if (win_last) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            wr_reg       <= wr_next;
            wc_reg       <= wc_next;
            kr_reg       <= 2'd0;
            kc_reg       <= 2'd0;
            pix_re_reg   <= 1'b1;
            pix_addr_reg <= first_addr_next;
            state_reg    <= S_LOAD;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign pix_re       = pix_re_reg;
  assign pix_addr     = pix_addr_reg;
  assign conv_data_in = ld_reg;
  assign conv_row     = ld_row_reg;
  assign conv_col     = ld_col_reg;
  // RAM and conv outputs are live only in the cycle they are consumed; zero elsewhere.
  assign conv_data    = ld_reg ? pix_rdata : 8'd0;
  assign res_we       = res_we_reg;
  assign res_addr     = res_addr_reg;
  assign res_data     = res_we_reg ? conv_out : 8'd0;

endmodule
